// File: rtl/spart_tx_arbiter_if.sv
// Bus bundle between byte requesters and the SPART transmit arbiter.
interface spart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   lock;
  logic [8*N_REQ-1:0] data;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   grant;
  logic               tbr;
  logic [7:0]         databus;
  logic               iocs;
  logic               iorw;
  logic [1:0]         ioaddr;
  logic               busy;

  // Requester / transmitter side
  modport master (
    output req, lock, data, tbr,
    input  ack, grant, databus, iocs, iorw, ioaddr, busy
  );

  // Arbiter side
  modport slave (
    input  req, lock, data, tbr,
    output ack, grant, databus, iocs, iorw, ioaddr, busy
  );
endinterface

// File: rtl/spart_tx_arbiter.sv
// Round-robin arbiter with per-requester lock that sequences byte writes
// into the SPART transmitter, paced by the transmitter's tbr flag.
module spart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TBR_TIMEOUT = 4
) (
  input logic               clk,
  input logic               rst,
  spart_tx_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TBR_TIMEOUT + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WRITE    = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (32'(i) == 32'(N_REQ - 1)) ? '0 : i + PW'(1);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             own_v_q, own_v_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    win_q, win_d;
  logic             wlock_q, wlock_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       databus_q, databus_d;
  logic             iocs_q, iocs_d;
  logic             iorw_q, iorw_d;
  logic             busy_q, busy_d;

  logic             rel;
  logic [PW-1:0]    ptr_eff;
  logic [N_REQ-1:0] elig;
  logic             found;
  logic [PW-1:0]    win_sel;
  logic [PW-1:0]    idx;
  logic [7:0]       wbyte;

  // Combinational winner search; a releasing owner moves the search start past itself
  always_comb begin
    rel     = own_v_q && !bus.lock[owner_q];
    ptr_eff = rel ? next_idx(owner_q) : rr_ptr_q;
    elig    = (own_v_q && !rel) ? (bus.req & onehot(owner_q)) : bus.req;
    found   = 1'b0;
    win_sel = '0;
    idx     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PW'((32'(ptr_eff) + i) % N_REQ);
      if (!found && elig[idx]) begin
        found   = 1'b1;
        win_sel = idx;
      end
    end
    wbyte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_sel == PW'(i)) wbyte = bus.data[8*i +: 8];
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    own_v_d   = own_v_q;
    owner_d   = owner_q;
    win_d     = win_q;
    wlock_d   = wlock_q;
    tcnt_d    = tcnt_q;
    ack_d     = '0;
    databus_d = databus_q;
    iocs_d    = 1'b0;
    iorw_d    = 1'b1;
    grant_d   = '0;
    busy_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rel) begin
          own_v_d  = 1'b0;
          rr_ptr_d = next_idx(owner_q);
        end
        if (bus.tbr && found) begin
          state_d   = WRITE;
          win_d     = win_sel;
          wlock_d   = bus.lock[win_sel];
          ack_d     = onehot(win_sel);
          databus_d = wbyte;
          iocs_d    = 1'b1;
          iorw_d    = 1'b0;
        end
      end
      WRITE: begin
        state_d = WAIT_LOW;
        tcnt_d  = '0;
        if (wlock_q) begin
          own_v_d = 1'b1;
          owner_d = win_q;
        end else begin
          own_v_d  = 1'b0;
          rr_ptr_d = next_idx(win_q);
        end
      end
      WAIT_LOW: begin
        if (!bus.tbr || tcnt_q == TW'(TBR_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // grant is the write winner during WRITE, else the held owner, else nothing
    if (state_d == WRITE) grant_d = onehot(win_d);
    else if (own_v_d)     grant_d = onehot(owner_d);
    busy_d = (state_d != IDLE);
  end

  // State and output registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      own_v_q   <= 1'b0;
      owner_q   <= '0;
      win_q     <= '0;
      wlock_q   <= 1'b0;
      tcnt_q    <= '0;
      ack_q     <= '0;
      grant_q   <= '0;
      databus_q <= 8'h00;
      iocs_q    <= 1'b0;
      iorw_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      own_v_q   <= own_v_d;
      owner_q   <= owner_d;
      win_q     <= win_d;
      wlock_q   <= wlock_d;
      tcnt_q    <= tcnt_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      databus_q <= databus_d;
      iocs_q    <= iocs_d;
      iorw_q    <= iorw_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.grant   = grant_q;
  assign bus.databus = databus_q;
  assign bus.iocs    = iocs_q;
  assign bus.iorw    = iorw_q;
  assign bus.ioaddr  = 2'b00;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_spart_tx_arbiter.sv
// Scoreboard bench for spart_tx_arbiter: requester queues drive req/lock/data,
// a monitor checks every write cycle against the expected write order.
module tb_spart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 4;

  logic clk;
  logic rst;

  spart_tx_arbiter_if #(.N_REQ(N)) bus ();

  spart_tx_arbiter #(.N_REQ(N), .TBR_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit auto_tbr = 0;

  logic [8:0]  src_q [N][$];   // {lock, byte} per requester
  logic [11:0] exp_q [$];      // {idx[3:0], byte}

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_src(input int i, input logic lk, input logic [7:0] b);
    src_q[i].push_back({lk, b});
  endtask

  task automatic push_exp(input int i, input logic [7:0] b);
    exp_q.push_back({4'(i), b});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
          src_q[3].size() == 0 && exp_q.size() == 0 && !bus.busy) begin
        done = 1;
        break;
      end
    end
    check(name, 32'(done), 32'd1);
  endtask

  // Requester model: pop on ack, present next byte with its lock
  initial begin
    bus.req  = '0;
    bus.lock = '0;
    bus.data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (bus.ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0) begin
          bus.req[i]         = 1'b1;
          bus.lock[i]        = src_q[i][0][8];
          bus.data[8*i +: 8] = src_q[i][0][7:0];
        end else begin
          bus.req[i]         = 1'b0;
          bus.lock[i]        = 1'b0;
          bus.data[8*i +: 8] = 8'h00;
        end
      end
    end
  end

  // Transmitter model: tbr drops after each write, recovers two cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (auto_tbr && bus.iocs) begin
        bus.tbr = 1'b0;
        repeat (2) @(negedge clk);
        bus.tbr = 1'b1;
      end
    end
  end

  // Monitor: every write cycle must match the head of the expected queue
  initial begin
    logic [11:0] e;
    logic [3:0]  oh;
    forever begin
      @(negedge clk);
      if (bus.iocs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(bus.databus), 32'hFFFF_FFFF);
        end else begin
          e  = exp_q.pop_front();
          oh = 4'b0001 << e[11:8];
          check("wr_databus", 32'(bus.databus), 32'(e[7:0]));
          check("wr_ack",     32'(bus.ack),     32'(oh));
          check("wr_grant",   32'(bus.grant),   32'(oh));
          check("wr_iorw",    32'(bus.iorw),    32'd0);
          check("wr_ioaddr",  32'(bus.ioaddr),  32'd0);
        end
      end else if (bus.ack != '0) begin
        check("ack_outside_write", 32'(bus.ack), 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    bit seen;
    rst     = 1'b0;
    bus.tbr = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_ack",     32'(bus.ack),     32'd0);
    check("rst_grant",   32'(bus.grant),   32'd0);
    check("rst_databus", 32'(bus.databus), 32'd0);
    check("rst_iocs",    32'(bus.iocs),    32'd0);
    check("rst_iorw",    32'(bus.iorw),    32'd1);
    check("rst_ioaddr",  32'(bus.ioaddr),  32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    rst     = 1'b1;
    bus.tbr = 1'b1;
    tick();

    // Round-robin: requesters 0,1,3 with two bytes each -> 0,1,3,0,1,3
    auto_tbr = 1;
    push_src(0, 0, 8'hA0); push_src(0, 0, 8'hA1);
    push_src(1, 0, 8'hB0); push_src(1, 0, 8'hB1);
    push_src(3, 0, 8'hD0); push_src(3, 0, 8'hD1);
    push_exp(0, 8'hA0); push_exp(1, 8'hB0); push_exp(3, 8'hD0);
    push_exp(0, 8'hA1); push_exp(1, 8'hB1); push_exp(3, 8'hD1);
    drain("rr_drain");

    // Lock packet from requester 0 with requester 2 pending
    push_src(0, 1, 8'h11); push_src(0, 1, 8'h22); push_src(0, 1, 8'h33);
    push_src(2, 0, 8'h5A);
    push_exp(0, 8'h11); push_exp(0, 8'h22); push_exp(0, 8'h33); push_exp(2, 8'h5A);
    drain("lock_drain");
    check("lock_grant_idle", 32'(bus.grant), 32'd0);

    // Single byte: latency, write strobes, WAIT_LOW exit on tbr=0
    auto_tbr = 0;
    bus.tbr  = 1'b1;
    push_src(1, 0, 8'hA5);
    push_exp(1, 8'hA5);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.req[1]) begin seen = 1; break; end
    end
    check("single_req_seen", 32'(seen), 32'd1);
    tick();
    check("single_iocs",  32'(bus.iocs),  32'd1);
    check("single_iorw",  32'(bus.iorw),  32'd0);
    check("single_ack",   32'(bus.ack),   32'b0010);
    check("single_grant", 32'(bus.grant), 32'b0010);
    tick();
    check("single_waitlow_busy", 32'(bus.busy), 32'd1);
    check("single_waitlow_iocs", 32'(bus.iocs), 32'd0);
    bus.tbr = 1'b0;
    tick();
    check("single_idle_busy", 32'(bus.busy), 32'd0);

    // Back-pressure: tbr low holds requester 3 off for 20 cycles
    push_src(3, 0, 8'hC3);
    push_exp(3, 8'hC3);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("bp_iocs", 32'(bus.iocs), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd0);
    end
    bus.tbr = 1'b1;
    tick();
    check("bp_release_iocs", 32'(bus.iocs), 32'd1);
    bus.tbr = 1'b0;
    drain("bp_drain");

    // Timeout: tbr stays high, WAIT_LOW lasts exactly TO cycles
    bus.tbr = 1'b1;
    push_src(0, 0, 8'hE0); push_src(1, 0, 8'hE1);
    push_exp(0, 8'hE0); push_exp(1, 8'hE1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.iocs) begin seen = 1; break; end
    end
    check("to_first_write", 32'(seen), 32'd1);
    gap = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      gap++;
      if (gap == TO)     check("to_last_waitlow_busy", 32'(bus.busy), 32'd1);
      if (gap == TO + 1) check("to_idle_busy",         32'(bus.busy), 32'd0);
      if (bus.iocs) break;
    end
    check("to_write_gap", 32'(gap), 32'(TO + 2));
    drain("to_drain");

    // Reset mid-write: requester 2 owns the bus, its second byte is aborted
    push_src(2, 1, 8'hF1); push_src(2, 1, 8'hF2);
    push_exp(2, 8'hF1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (exp_q.size() == 0 && !bus.busy && bus.req[2]) begin seen = 1; break; end
    end
    check("rw_reached_idle", 32'(seen), 32'd1);
    check("rw_owner_grant",  32'(bus.grant), 32'b0100);
    @(posedge clk);
    #2;
    check("rw_in_write", 32'(bus.iocs), 32'd1);
    rst = 1'b0;
    #1;
    check("rw_rst_iocs",  32'(bus.iocs),  32'd0);
    check("rw_rst_iorw",  32'(bus.iorw),  32'd1);
    check("rw_rst_ack",   32'(bus.ack),   32'd0);
    check("rw_rst_grant", 32'(bus.grant), 32'd0);
    check("rw_rst_busy",  32'(bus.busy),  32'd0);
    push_src(0, 0, 8'hF0);
    repeat (3) tick();
    rst = 1'b1;
    push_exp(0, 8'hF0); push_exp(2, 8'hF2);
    drain("rw_drain");

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
